axi_pattern_test_master: RTL and testbench

// - Parametrised AXI4 traffic master for DDR-SDRAM controller self-test; successor to axi_self_test_master.
// - Writes a whole test region in bursts with a selectable data pattern, then reads it back and compares.
// - Reports pass/fail, a saturating error count and the first failing address.
// - Sits between the bench (or an on-chip BIST controller) and the AXI4 slave port of ddr_sdram_ctrl.

---
 rtl/axi_test_pkg.sv | 42 ++++
 rtl/axi_test_pattern_gen.sv | 60 ++++++
 rtl/axi_pattern_test_master.sv | 206 ++++++++++++++++++++
 tb/tb_axi_pattern_test_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_test_pkg
// Purpose  : Shared definitions for the AXI4 pattern test master: pattern
//            mode encodings, FSM state type and the per-beat pattern function.
// Revision : 1.0 - initial release
// ============================================================================
package axi_test_pkg;

  localparam logic [1:0] PAT_INCR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_WALK = 2'd2;
  localparam logic [1:0] PAT_SEED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // 32-bit pattern word for one beat. walk_idx is the beat index already
  // reduced modulo the data width; positions beyond bit 31 yield zero.
  function automatic logic [31:0] pattern_word(input logic [1:0]  mode,
                                               input logic [31:0] addr,
                                               input logic [7:0]  walk_idx,
                                               input logic [31:0] seed);
    logic [31:0] word;
    case (mode)
      PAT_INCR: word = addr;
      PAT_INV:  word = ~addr;
      PAT_WALK: word = (walk_idx < 8'd32) ? (32'd1 << walk_idx[4:0]) : 32'd0;
      default:  word = addr ^ seed;
    endcase
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_test_pattern_gen
// Purpose  : Registered pattern word generator shared by the write and the
//            read-compare datapaths.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            addr, beat        - byte address / in-burst index of the beat
//                                the word is wanted for on the next cycle
//            mode, seed        - pattern select and seed
//            data              - registered pattern word (D_WIDTH bits)
// Revision : 1.0 - initial release
// ============================================================================
module axi_test_pattern_gen
  import axi_test_pkg::*;
#(
  parameter int A_WIDTH_TEST = 12,
  parameter int D_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [A_WIDTH_TEST-1:0] addr,
  input  logic [7:0]              beat,
  input  logic [1:0]              mode,
  input  logic [31:0]             seed,
  output logic [D_WIDTH-1:0]      data
);

  // D_WIDTH is a power of two, so the modulo is a mask (capped at 8 bits).
  localparam int WALK_MOD = (D_WIDTH < 256) ? D_WIDTH : 256;

  logic [7:0]         w_walk_idx;
  logic [31:0]        w_word;
  logic [D_WIDTH-1:0] data_d;
  logic [D_WIDTH-1:0] data_q;

  assign w_walk_idx = beat & 8'(WALK_MOD - 1);
  assign w_word     = pattern_word(mode, 32'(addr), w_walk_idx, seed);

  // 32-bit word truncated to narrow buses, replicated across wide ones.
  generate
    if (D_WIDTH < 32) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^w_word[31:D_WIDTH];
      assign data_d    = w_word[D_WIDTH-1:0];
    end else begin : g_repl
      for (genvar gi = 0; gi < D_WIDTH; gi++) begin : g_bit
        assign data_d[gi] = w_word[gi % 32];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/axi_pattern_test_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_pattern_test_master
// Purpose  : AXI4 traffic master for DDR controller self-test. Writes the
//            test region in bursts with a selectable pattern, reads it back
//            and compares, logging error flag, saturating count and first
//            failing address.
// Ports    : clk, rst                    - clock, sync active-high reset
//            start, mode, seed           - run control (start is a pulse)
//            busy, done, error,
//            error_cnt, first_err_addr   - run status / error log
//            aw*, w*, b*, ar*, r*        - AXI4 master channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_pattern_test_master
  import axi_test_pkg::*;
#(
  parameter int         A_WIDTH      = 26,
  parameter int         D_WIDTH      = 16,
  parameter int         D_LEVEL      = 1,
  parameter int         A_WIDTH_TEST = 12,
  parameter logic [7:0] WBURST_LEN   = 8'd7,
  parameter logic [7:0] RBURST_LEN   = 8'd7,
  parameter int         ECNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [31:0]        seed,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ECNT_W-1:0]  error_cnt,
  output logic [A_WIDTH-1:0] first_err_addr,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  input  logic               arready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  input  logic               rvalid,
  output logic               rready,
  input  logic               rlast,
  input  logic [D_WIDTH-1:0] rdata
);

  localparam int WB_BYTES = (int'(WBURST_LEN) + 1) << D_LEVEL;
  localparam int RB_BYTES = (int'(RBURST_LEN) + 1) << D_LEVEL;
  // A burst covering the whole region truncates to 0: base wraps at once.
  localparam logic [A_WIDTH_TEST-1:0] C_WB_STEP = WB_BYTES[A_WIDTH_TEST-1:0];
  localparam logic [A_WIDTH_TEST-1:0] C_RB_STEP = RB_BYTES[A_WIDTH_TEST-1:0];

  state_e                  state_q, state_d;
  logic [A_WIDTH_TEST-1:0] base_q, base_d;
  logic [7:0]              beat_q, beat_d;
  logic [1:0]              mode_q, mode_d;
  logic [31:0]             seed_q, seed_d;
  logic                    error_q, error_d;
  logic [ECNT_W-1:0]       ecnt_q, ecnt_d;
  logic [A_WIDTH_TEST-1:0] ferr_q, ferr_d;

  logic [A_WIDTH_TEST-1:0] w_addr_q;
  logic [A_WIDTH_TEST-1:0] w_addr_d;
  logic [A_WIDTH_TEST-1:0] w_wbase_inc;
  logic [A_WIDTH_TEST-1:0] w_rbase_inc;
  logic [D_WIDTH-1:0]      w_pat;
  logic                    w_rbeat;
  logic                    w_mismatch;

  assign w_addr_q    = base_q + A_WIDTH_TEST'(32'(beat_q) << D_LEVEL);
  assign w_addr_d    = base_d + A_WIDTH_TEST'(32'(beat_d) << D_LEVEL);
  assign w_wbase_inc = base_q + C_WB_STEP;
  assign w_rbase_inc = base_q + C_RB_STEP;

  // Fed with next-state pointers so w_pat always matches the current beat.
  axi_test_pattern_gen #(
    .A_WIDTH_TEST (A_WIDTH_TEST),
    .D_WIDTH      (D_WIDTH)
  ) u_pattern_gen (
    .clk  (clk),
    .rst  (rst),
    .addr (w_addr_d),
    .beat (beat_d),
    .mode (mode_d),
    .seed (seed_d),
    .data (w_pat)
  );

  assign w_rbeat    = (state_q == ST_R) && rvalid;
  assign w_mismatch = w_rbeat &&
                      ((rdata != w_pat) || (rlast != (beat_q == RBURST_LEN)));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    error_d = error_q;
    ecnt_d  = ecnt_q;
    ferr_d  = ferr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_AW;
          base_d  = '0;
          beat_d  = 8'd0;
          mode_d  = mode;
          seed_d  = seed;
          error_d = 1'b0;
          ecnt_d  = '0;
          ferr_d  = '0;
        end
      end
      ST_AW: if (awready) state_d = ST_W;
      ST_W: begin
        if (wready) begin
          if (beat_q == WBURST_LEN) begin
            beat_d  = 8'd0;
            state_d = ST_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_B: begin
        if (bvalid) begin
          base_d  = w_wbase_inc;
          // Base wrapping to zero means the whole region has been written.
          state_d = (w_wbase_inc == '0) ? ST_AR : ST_AW;
        end
      end
      ST_AR: if (arready) state_d = ST_R;
      ST_R: begin
        if (rvalid) begin
          if (beat_q == RBURST_LEN) begin
            beat_d  = 8'd0;
            base_d  = w_rbase_inc;
            state_d = (w_rbase_inc == '0) ? ST_DONE : ST_AR;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_mismatch) begin
      error_d = 1'b1;
      if (ecnt_q != {ECNT_W{1'b1}}) ecnt_d = ecnt_q + ECNT_W'(1);
      if (!error_q) ferr_d = w_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= 8'd0;
      mode_q  <= PAT_INCR;
      seed_q  <= 32'd0;
      error_q <= 1'b0;
      ecnt_q  <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      error_q <= error_d;
      ecnt_q  <= ecnt_d;
      ferr_q  <= ferr_d;
    end
  end

  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign error          = error_q;
  assign error_cnt      = ecnt_q;
  assign first_err_addr = A_WIDTH'(ferr_q);

  assign awvalid = (state_q == ST_AW);
  assign awaddr  = A_WIDTH'(base_q);
  assign awlen   = WBURST_LEN;
  assign wvalid  = (state_q == ST_W);
  assign wlast   = (state_q == ST_W) && (beat_q == WBURST_LEN);
  assign wdata   = w_pat;
  assign bready  = (state_q == ST_B);
  assign arvalid = (state_q == ST_AR);
  assign araddr  = A_WIDTH'(base_q);
  assign arlen   = RBURST_LEN;
  assign rready  = (state_q == ST_R);

endmodule
`default_nettype wire

// File: tb/tb_axi_pattern_test_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_pattern_test_master
// Purpose  : Self-checking bench for axi_pattern_test_master: memory slave
//            model with optional stalls, read corruption and early rlast,
//            plus a small-counter instance for error_cnt saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_pattern_test_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, error;
  logic [15:0] error_cnt;
  logic [25:0] first_err_addr, awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [7:0]  awlen, arlen;
  logic [15:0] wdata, rdata;

  axi_pattern_test_master u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .error(error), .error_cnt(error_cnt),
    .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
  );

  // Second instance: tiny region, 4-bit counter, slave returns only bad beats.
  logic        start_b, busy_b, done_b, error_b;
  logic [1:0]  mode_b;
  logic [31:0] seed_b;
  logic [3:0]  ecnt_b;
  logic [25:0] ferr_b, awaddr_b, araddr_b;
  logic        awvalid_b, awready_b, wvalid_b, wready_b, wlast_b, bvalid_b, bready_b;
  logic        arvalid_b, arready_b, rvalid_b, rready_b, rlast_b;
  logic [7:0]  awlen_b, arlen_b;
  logic [15:0] wdata_b, rdata_b;

  axi_pattern_test_master #(.A_WIDTH_TEST(8), .ECNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .seed(seed_b),
    .busy(busy_b), .done(done_b), .error(error_b), .error_cnt(ecnt_b),
    .first_err_addr(ferr_b),
    .awvalid(awvalid_b), .awready(awready_b), .awaddr(awaddr_b), .awlen(awlen_b),
    .wvalid(wvalid_b), .wready(wready_b), .wlast(wlast_b), .wdata(wdata_b),
    .bvalid(bvalid_b), .bready(bready_b),
    .arvalid(arvalid_b), .arready(arready_b), .araddr(araddr_b), .arlen(arlen_b),
    .rvalid(rvalid_b), .rready(rready_b), .rlast(rlast_b), .rdata(rdata_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [15:0] mem [0:2047];
  int          stall_pct = 0;
  logic        corrupt_en = 1'b0, early_en = 1'b0, first_rd = 1'b1;
  logic [11:0] corrupt_addr = 12'h310;
  int          aw_cnt, ar_cnt, stable_err;
  logic [25:0] aw_log [0:1];
  logic [7:0]  awlen_seen, rlen;
  logic [10:0] wptr, rptr;
  logic [7:0]  rbeat;
  logic        b_pend, b_hold, r_busy, r_hold;
  logic        p_aw, p_w, p_ar;
  logic [25:0] p_awaddr, p_araddr;
  logic [15:0] p_wdata;
  logic        p_wlast;

  function automatic bit stall();
    return ($urandom_range(0, 99) < stall_pct);
  endfunction

  task automatic slave_clear();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = 16'd0;
    b_pend = 1'b0; b_hold = 1'b0; r_busy = 1'b0; r_hold = 1'b0;
    p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    wptr = 11'd0; rptr = 11'd0; rbeat = 8'd0; rlen = 8'd0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
      end else begin
        // payload of a stalled transfer must still be presented unchanged
        if (p_aw && (!awvalid || awaddr !== p_awaddr)) stable_err++;
        if (p_w  && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stable_err++;
        if (p_ar && (!arvalid || araddr !== p_araddr)) stable_err++;

        awready = awvalid && !stall();
        wready  = wvalid && !stall();
        bvalid  = b_hold || (b_pend && !stall());
        arready = arvalid && !stall();
        rvalid  = r_hold || (r_busy && !stall());
        rdata   = mem[rptr];
        if (corrupt_en && {rptr, 1'b0} == corrupt_addr) rdata[3] = ~rdata[3];
        rlast   = (rbeat == rlen) || (early_en && first_rd && rbeat == 8'd5);

        p_aw = awvalid && !awready; p_awaddr = awaddr;
        p_w  = wvalid && !wready;   p_wdata  = wdata; p_wlast = wlast;
        p_ar = arvalid && !arready; p_araddr = araddr;

        if (awvalid && awready) begin
          if (aw_cnt < 2) aw_log[aw_cnt] = awaddr;
          aw_cnt++;
          wptr = awaddr[11:1];
          awlen_seen = awlen;
        end
        if (wvalid && wready) begin
          mem[wptr] = wdata;
          wptr++;
          if (wlast) b_pend = 1'b1;
        end
        if (bvalid && bready) begin
          b_pend = 1'b0; b_hold = 1'b0;
        end else begin
          b_hold = bvalid;
        end
        if (arvalid && arready) begin
          rptr = araddr[11:1]; rlen = arlen; rbeat = 8'd0; r_busy = 1'b1; ar_cnt++;
        end
        if (rvalid && rready) begin
          rptr++;
          if (rbeat == rlen) begin
            r_busy = 1'b0; first_rd = 1'b0;
          end
          rbeat++;
          r_hold = 1'b0;
        end else begin
          r_hold = rvalid;
        end
      end
    end
  end

  // ---------------- sequencing ----------------
  task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
    @(negedge clk);
    mode = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] m, input logic [31:0] s);
    aw_cnt = 0; ar_cnt = 0; stable_err = 0; first_rd = 1'b1;
    pulse_start(m, s);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40000 && !done; i++) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'd0;
    start_b = 1'b0; mode_b = 2'd0; seed_b = 32'd0;
    awready_b = 1'b1; wready_b = 1'b1; bvalid_b = 1'b1; arready_b = 1'b1;
    rvalid_b = 1'b1; rlast_b = 1'b0; rdata_b = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cnt",   64'(error_cnt), 64'd0);
    check("rst_ferr",  64'(first_err_addr), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);

    // Run 1: ideal slave, INCR
    begin_run(2'd0, 32'd0);
    check("r1_busy_after_start", 64'(busy), 64'd1);
    wait_done("r1");
    check("r1_error", 64'(error), 64'd0);
    check("r1_cnt", 64'(error_cnt), 64'd0);
    check("r1_aw_bursts", 64'(aw_cnt), 64'd256);
    check("r1_ar_bursts", 64'(ar_cnt), 64'd256);
    check("r1_awaddr1", 64'(aw_log[1]), 64'h10);
    check("r1_awlen", 64'(awlen_seen), 64'd7);
    check("r1_arlen", 64'(rlen), 64'd7);
    check("r1_mem_310", 64'(mem[11'h188]), 64'h0310);
    check("r1_mem_ffe", 64'(mem[11'h7FF]), 64'h0FFE);

    // Run 2: random stalls, SEED; a start while busy must be ignored
    stall_pct = 30;
    begin_run(2'd3, 32'hA5A5_5A5A);
    repeat (50) @(negedge clk);
    pulse_start(2'd0, 32'd0);
    wait_done("r2");
    check("r2_error", 64'(error), 64'd0);
    check("r2_cnt", 64'(error_cnt), 64'd0);
    check("r2_stable", 64'(stable_err), 64'd0);
    check("r2_aw_bursts", 64'(aw_cnt), 64'd256);
    check("r2_mem_310", 64'(mem[11'h188]), 64'h594A);

    // Run 3: one corrupted read beat at byte 0x310
    stall_pct = 0; corrupt_en = 1'b1;
    begin_run(2'd0, 32'd0);
    wait_done("r3");
    corrupt_en = 1'b0;
    check("r3_error", 64'(error), 64'd1);
    check("r3_cnt", 64'(error_cnt), 64'd1);
    check("r3_ferr", 64'(first_err_addr), 64'h310);

    // Run 4: early rlast on beat 5 of the first read burst, INV
    early_en = 1'b1;
    begin_run(2'd1, 32'd0);
    wait_done("r4");
    early_en = 1'b0;
    check("r4_error", 64'(error), 64'd1);
    check("r4_cnt", 64'(error_cnt), 64'd1);
    check("r4_ferr", 64'(first_err_addr), 64'hA);
    check("r4_mem_310", 64'(mem[11'h188]), 64'hFCEF);

    // Reset while done with a logged error
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_done", 64'(done), 64'd0);
    check("rst2_error", 64'(error), 64'd0);
    check("rst2_cnt", 64'(error_cnt), 64'd0);
    check("rst2_ferr", 64'(first_err_addr), 64'd0);

    // Run 5: reset in the middle of a write burst, then WALK with stalls
    begin_run(2'd0, 32'd0);
    for (int i = 0; i < 500 && !(wvalid && awaddr == 26'h20); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("r5_mid_w", 64'(wvalid), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("r5_rst_busy", 64'(busy), 64'd0);
    check("r5_rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    stall_pct = 20;
    begin_run(2'd2, 32'd0);
    wait_done("r5");
    check("r5_error", 64'(error), 64'd0);
    check("r5_cnt", 64'(error_cnt), 64'd0);
    check("r5_mem_310", 64'(mem[11'h188]), 64'h0001);
    check("r5_mem_31e", 64'(mem[11'h18F]), 64'h0080);

    // Saturation: 128 bad read beats into a 4-bit counter
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 5000 && !done_b; i++) @(negedge clk);
    check("sat_done", 64'(done_b), 64'd1);
    check("sat_cnt", 64'(ecnt_b), 64'hF);
    check("sat_error", 64'(error_b), 64'd1);
    check("sat_ferr", 64'(ferr_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
